// File: rtl/gpio_pkg.sv
// gpio_pkg: shared default width and reset value for the gpio block.
package gpio_pkg;
  localparam int GPIO_WIDTH = 32;
  localparam logic [GPIO_WIDTH-1:0] GPIO_RESET_VALUE = '0;
endpackage

// File: rtl/gpio.sv
// gpio: write-only output register with registered read-back.
// Define GPIO_OUT_REG_EN to add one pipeline stage in front of gpio_out.
module gpio
  import gpio_pkg::*;
#(
  parameter int WIDTH = GPIO_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(GPIO_RESET_VALUE)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic             re,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] gpio_out
);
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_rd;
  // Read samples the pre-edge r_out, so a same-edge write is not yet visible.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      r_out <= RESET_VALUE;
      r_rd  <= '0;
    end else begin
      if (we) r_out <= data_in;
      if (re) r_rd  <= r_out;
    end
  assign data_out = r_rd;
`ifdef GPIO_OUT_REG_EN
  logic [WIDTH-1:0] r_pin;
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_pin <= RESET_VALUE;
    else        r_pin <= r_out;
  assign gpio_out = r_pin;
`else
  assign gpio_out = r_out;
`endif
endmodule

// File: tb/tb_gpio.sv
// tb_gpio: directed self-checking bench for gpio.
module tb_gpio;
  localparam int W = 32;
`ifdef GPIO_OUT_REG_EN
  localparam int GL = 2;
`else
  localparam int GL = 1;
`endif
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         we = 1'b0;
  logic         re = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] data_out;
  logic [W-1:0] gpio_out;
  int n_checks = 0;
  int n_fail = 0;

  gpio #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .we(we), .re(re),
    .data_in(data_in), .data_out(data_out), .gpio_out(gpio_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    check("rst_gpio_async", gpio_out, 32'h0);
    check("rst_data_async", data_out, 32'h0);
    step();
    reset = 1'b1;
    step();
    check("rel_gpio", gpio_out, 32'h0);
    check("rel_data", data_out, 32'h0);
    we = 1'b1; data_in = 32'hA5A5A5A5;
    step();
    we = 1'b0; data_in = 32'h0;
    repeat (GL-1) step();
    check("wr_a5_gpio", gpio_out, 32'hA5A5A5A5);
    check("wr_a5_no_read", data_out, 32'h0);
    step();
    check("hold_a5_gpio", gpio_out, 32'hA5A5A5A5);
    re = 1'b1;
    step();
    re = 1'b0;
    check("rd_a5", data_out, 32'hA5A5A5A5);
    step();
    check("rd_a5_held", data_out, 32'hA5A5A5A5);
    we = 1'b1; data_in = 32'h12345678;
    step();
    we = 1'b0; re = 1'b1; data_in = 32'h0;
    step();
    re = 1'b0;
    check("rd_after_wr", data_out, 32'h12345678);
    repeat (GL-1) step();
    check("wr_1234_gpio", gpio_out, 32'h12345678);
    we = 1'b1; re = 1'b1; data_in = 32'hDEADBEEF;
    step();
    we = 1'b0; re = 1'b0; data_in = 32'h0;
    check("rbw_data_old", data_out, 32'h12345678);
    repeat (GL-1) step();
    check("rbw_gpio_new", gpio_out, 32'hDEADBEEF);
    re = 1'b1;
    step();
    re = 1'b0;
    check("rd_dead", data_out, 32'hDEADBEEF);
    we = 1'b1; data_in = 32'hFFFFFFFF;
    step();
    we = 1'b0; re = 1'b1;
    step();
    re = 1'b0;
    repeat (GL-1) step();
    check("ones_gpio", gpio_out, 32'hFFFFFFFF);
    check("ones_data", data_out, 32'hFFFFFFFF);
    #2;
    we = 1'b1; re = 1'b1; data_in = 32'h55AA55AA;
    reset = 1'b0;
    #1;
    check("async_gpio_clr", gpio_out, 32'h0);
    check("async_data_clr", data_out, 32'h0);
    step();
    check("rst_discard_gpio", gpio_out, 32'h0);
    check("rst_discard_data", data_out, 32'h0);
    we = 1'b0; re = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    we = 1'b1; data_in = 32'h0F0F0F0F;
    step();
    we = 1'b0; re = 1'b1;
    step();
    re = 1'b0;
    repeat (GL-1) step();
    check("post_rst_gpio", gpio_out, 32'h0F0F0F0F);
    check("post_rst_data", data_out, 32'h0F0F0F0F);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/gpio.md
GPIO -- requirements
Module: gpio

Interface
Parameters (name, default, meaning):
REQ-001 WIDTH, 32, bit width of data_in, data_out, gpio_out and the internal output register.
REQ-002 RESET_VALUE, WIDTH'(0), value loaded into the output register on reset.

Ports (name, direction, width, meaning):
REQ-003 clk, input, 1, single clock; all state updates on the rising edge.
REQ-004 reset, input, 1, asynchronous active-low reset: asserts immediately on low, releases synchronously to clk.
REQ-005 we, input, 1, write enable; sampled on the rising clk edge.
REQ-006 re, input, 1, read enable; sampled on the rising clk edge.
REQ-007 data_in, input, WIDTH, write data.
REQ-008 data_out, output, WIDTH, registered read-back data.
REQ-009 gpio_out, output, WIDTH, pin-level output driven from the output register.

Function
REQ-010 The block SHALL hold one WIDTH-bit output register, out_reg.
REQ-011 On a rising edge with we=1, out_reg SHALL load data_in; with we=0, out_reg SHALL hold its value.
REQ-012 gpio_out SHALL equal out_reg, so a write is visible on the pins one edge after we is sampled.
REQ-013 On a rising edge with re=1, data_out SHALL load out_reg's pre-edge value (1-cycle read latency).
REQ-014 With re=0, data_out SHALL hold its last value; it SHALL NOT return to zero.
REQ-015 With we=1 and re=1 on the same edge, data_out SHALL capture the old out_reg value and out_reg SHALL take data_in (read-before-write).
REQ-016 A read issued on the edge immediately after a write SHALL return the newly written value.
REQ-017 There is no handshake, no back-pressure and no busy state; every cycle accepts a new we/re.
REQ-018 No arithmetic is performed; all data paths are full WIDTH with no truncation or extension.

Reset
REQ-019 While reset=0, out_reg SHALL be RESET_VALUE, gpio_out SHALL be RESET_VALUE and data_out SHALL be 0, independent of clk.
REQ-020 Asserting reset mid-operation SHALL discard any write or read on that cycle.
REQ-021 The first edge after reset release SHALL process we/re normally.

Configuration
REQ-022 Macro GPIO_OUT_REG_EN, when defined, SHALL add one output pipeline register between out_reg and gpio_out.
- gpio_out then updates two edges after the write.
- The added stage resets to RESET_VALUE.
- Read-back still comes from out_reg with 1-cycle latency.
REQ-023 When GPIO_OUT_REG_EN is undefined, gpio_out SHALL be driven directly from out_reg as in REQ-012.

Structure
REQ-024 The shared package gpio_pkg SHALL hold the default-width constant (32) and the default reset-value constant (0).
REQ-025 The design SHALL be a single module; no sub-module is required.

Verification
REQ-026 Reset low for 1 cycle, then release -> gpio_out=0x00000000 and data_out=0x00000000.
REQ-027 we=1, data_in=0xA5A5A5A5 for one edge -> gpio_out=0xA5A5A5A5 after that edge (after two edges with GPIO_OUT_REG_EN); value held with we=0.
REQ-028 re=1 for one edge after REQ-027 -> data_out=0xA5A5A5A5 after that edge and held after re drops.
REQ-029 Write 0x12345678, then read -> gpio_out=0x12345678, then data_out=0x12345678.
REQ-030 we=1, re=1 together with data_in=0xDEADBEEF while out_reg=0x12345678 -> data_out=0x12345678 and gpio_out=0xDEADBEEF.
REQ-031 Assert reset between clock edges while holding a value -> gpio_out and data_out clear immediately, before the next edge.
